// File: rtl/fetch_queue_if.sv
// Bundle of the fetch-side (L1I) and decode-side handshakes of the fetch queue.
// The queue itself uses the master modport; the environment uses slave.
interface fetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic                  fetch_ready;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_instruction;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  out_ready;
  logic [CntW-1:0]       count;

  modport master (
    output fetch_valid, fetch_address, out_valid, out_instruction, out_pc, count,
    input  fetch_ready, fetch_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  fetch_valid, fetch_address, out_valid, out_instruction, out_pc, count,
    output fetch_ready, fetch_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential L1I requests and buffers {instruction, pc}
// in a circular buffer for decode. Redirect flushes and restarts fetch at redirect_pc.
module fetch_queue #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned          PC_STEP    = 4
) (
  input logic           clock,
  input logic           reset_n,
  fetch_queue_if.master bus_io
);
  localparam int unsigned           PtrW = $clog2(DEPTH);
  localparam int unsigned           CntW = PtrW + 1;
  localparam logic [CntW-1:0]       Full = CntW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] Step = ADDR_WIDTH'(PC_STEP);

  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];

  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  logic fetch_valid;
  logic push;
  logic pop;

  assign fetch_valid = (count_q < Full) && !bus_io.redirect;
  assign push        = fetch_valid && bus_io.fetch_ready;
  // Redirect squashes the pop as well: nothing is consumed in a flush cycle.
  assign pop         = (count_q != '0) && bus_io.out_ready && !bus_io.redirect;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (bus_io.redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = bus_io.redirect_pc;
    end else begin
      if (push) begin
        tail_d     = tail_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + Step;
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Storage is not reset; entries are only observed while counted as valid.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[tail_q] <= bus_io.fetch_data;
      pc_q[tail_q]    <= fetch_pc_q;
    end
  end

  assign bus_io.fetch_valid     = fetch_valid;
  assign bus_io.fetch_address   = fetch_pc_q;
  assign bus_io.out_valid       = (count_q != '0);
  assign bus_io.out_instruction = instr_q[head_q];
  assign bus_io.out_pc          = pc_q[head_q];
  assign bus_io.count           = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a DEPTH=4 and a DEPTH=2 instance share stimulus and are
// compared every cycle against an unbounded-log FIFO model, plus directed literal checks.
module tb_fetch_queue;
  localparam int unsigned LogN = 4096;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // Model: every pushed entry is appended to a log; the live queue is log[rd .. wr-1].
  int          dep    [2] = '{4, 2};
  int          wr     [2];
  int          rd     [2];
  logic [31:0] mpc    [2];
  logic [31:0] log_pc [2][LogN];
  logic [31:0] log_in [2][LogN];

  always #5 clock = ~clock;

  fetch_queue_if #(.DEPTH(4)) bus4 ();
  fetch_queue_if #(.DEPTH(2)) bus2 ();

  assign bus4.fetch_ready = fetch_ready;
  assign bus4.fetch_data  = fetch_data;
  assign bus4.redirect    = redirect;
  assign bus4.redirect_pc = redirect_pc;
  assign bus4.out_ready   = out_ready;
  assign bus2.fetch_ready = fetch_ready;
  assign bus2.fetch_data  = fetch_data;
  assign bus2.redirect    = redirect;
  assign bus2.redirect_pc = redirect_pc;
  assign bus2.out_ready   = out_ready;

  fetch_queue #(.DEPTH(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus_io(bus4));
  fetch_queue #(.DEPTH(2)) dut2 (.clock(clock), .reset_n(reset_n), .bus_io(bus2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      int occ = wr[m] - rd[m];
      bit fv  = (occ < dep[m]) && !redirect;
      bit pu  = fv && fetch_ready;
      bit po  = (occ != 0) && out_ready;
      if (!reset_n) begin
        rd[m]  = wr[m];
        mpc[m] = 32'h0;
      end else if (redirect) begin
        rd[m]  = wr[m];
        mpc[m] = redirect_pc;
      end else begin
        if (pu) begin
          log_pc[m][wr[m] % LogN] = mpc[m];
          log_in[m][wr[m] % LogN] = fetch_data;
          wr[m]++;
          mpc[m] += 32'd4;
        end
        if (po) rd[m]++;
      end
    end
    if (!reset_n) started = 1'b1;
  endtask

  task automatic check_dut(input int m, input logic fv, input logic [31:0] fa,
                           input logic ov, input logic [31:0] oi, input logic [31:0] op,
                           input logic [31:0] cnt);
    int    occ = wr[m] - rd[m];
    string p   = $sformatf("d%0d_", dep[m]);
    chk({p, "count"}, cnt, 32'(occ));
    chk({p, "out_valid"}, 32'(ov), 32'(occ != 0));
    chk({p, "fetch_valid"}, 32'(fv), 32'((occ < dep[m]) && !redirect));
    chk({p, "fetch_address"}, fa, mpc[m]);
    if (occ != 0) begin
      chk({p, "out_pc"}, op, log_pc[m][rd[m] % LogN]);
      chk({p, "out_instruction"}, oi, log_in[m][rd[m] % LogN]);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      check_dut(0, bus4.fetch_valid, bus4.fetch_address, bus4.out_valid,
                bus4.out_instruction, bus4.out_pc, 32'(bus4.count));
      check_dut(1, bus2.fetch_valid, bus2.fetch_address, bus2.out_valid,
                bus2.out_instruction, bus2.out_pc, 32'(bus2.count));
    end
  end

  // Apply inputs for one rising edge; returns 2 time units after that edge.
  task automatic drive(input bit rn, input bit fr, input bit orr, input bit rdir,
                       input logic [31:0] rpc);
    reset_n     = rn;
    fetch_ready = fr;
    out_ready   = orr;
    redirect    = rdir;
    redirect_pc = rpc;
    fetch_data  = $urandom;
    @(posedge clock);
    model_update();
    #2;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      wr[m]  = 0;
      rd[m]  = 0;
      mpc[m] = 32'h0;
    end
    reset_n = 1'b0; fetch_ready = 1'b0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; fetch_data = 32'h0;

    do_reset();
    chk("rst_count", 32'(bus4.count), 32'd0);
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_fetch_address", bus4.fetch_address, 32'h0);

    // Streaming
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("stream_pc0", bus4.out_pc, 32'h0);
    chk("stream_cnt0", 32'(bus4.count), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("stream_pc1", bus4.out_pc, 32'h4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("stream_pc2", bus4.out_pc, 32'h8);
    chk("stream_cnt2", 32'(bus4.count), 32'd1);

    // Fill and stall
    do_reset();
    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("fill_count", 32'(bus4.count), 32'd4);
    chk("fill_fetch_valid", 32'(bus4.fetch_valid), 32'd0);
    chk("fill_fetch_address", bus4.fetch_address, 32'h10);
    chk("fill_head", bus4.out_pc, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("fill_pop_count", 32'(bus4.count), 32'd3);
    chk("fill_pop_head", bus4.out_pc, 32'h4);
    chk("fill_pop_addr", bus4.fetch_address, 32'h10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("fill_resume_count", 32'(bus4.count), 32'd4);
    chk("fill_resume_addr", bus4.fetch_address, 32'h14);

    // Miss
    do_reset();
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("miss_addr", bus4.fetch_address, 32'h8);
      chk("miss_count", 32'(bus4.count), 32'd2);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("miss_hit_count", 32'(bus4.count), 32'd3);
    chk("miss_hit_addr", bus4.fetch_address, 32'hC);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("miss_drain_pc4", bus4.out_pc, 32'h4);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("miss_drain_pc8", bus4.out_pc, 32'h8);
    chk("miss_drain_cnt1", 32'(bus4.count), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("miss_drain_empty", 32'(bus4.count), 32'd0);

    // Redirect
    do_reset();
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_pre_count", 32'(bus4.count), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    chk("redir_count", 32'(bus4.count), 32'd0);
    chk("redir_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("redir_addr", bus4.fetch_address, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_out_pc", bus4.out_pc, 32'h100);
    chk("redir_addr_next", bus4.fetch_address, 32'h104);

    // Reset while full, with redirect asserted
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rstmid_full", 32'(bus4.count), 32'd4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    chk("rstmid_count", 32'(bus4.count), 32'd0);
    chk("rstmid_addr", bus4.fetch_address, 32'h0);

    // Random traffic, checked every cycle by the negedge compare
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(63) != 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
            ($urandom_range(15) == 0), ($urandom & 32'hFFFF_FFFC));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
